mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory between the IF stage (instruction fetch) and the MEM stage (load/store).
//  Sits between the CPU pipeline and the unified memory.
//  Per-requester stall outputs feed the hazard logic, which gates PCWrite/IFIDWrite and freezes the pipeline.
//  Data requests win by default (the older instruction in the pipeline); a watchdog bounds each access.
// PARAMETERS
//  ADDR_W         32  address width
//  DATA_W         32  data width
//  TIMEOUT_CYC    64  max cycles in BUSY without mem_ack_i before abort (>=2)
//  MAX_DM_STREAK  4   consecutive DM grants allowed while IF waits (ARB_FAIR_EN only)
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       asynchronous, active-low reset
//  if_req_i     in   1       fetch request; held with if_addr_i until if_ready_o
//  if_addr_i    in   ADDR_W  fetch address
//  if_rdata_o   out  DATA_W  fetched instruction, valid while if_ready_o
//  if_ready_o   out  1       1-cycle completion pulse to IF
//  if_stall_o   out  1       if_req_i & ~if_ready_o
//  dm_req_i     in   1       data request; held with addr/we/wdata until dm_ready_o
//  dm_we_i      in   1       1=store, 0=load
//  dm_addr_i    in   ADDR_W  data address
//  dm_wdata_i   in   DATA_W  store data
//  dm_rdata_o   out  DATA_W  load data, valid while dm_ready_o
//  dm_ready_o   out  1       1-cycle completion pulse to MEM
//  dm_stall_o   out  1       dm_req_i & ~dm_ready_o
//  mem_req_o    out  1       memory request; held until mem_ack_i
//  mem_we_o     out  1       memory write enable
//  mem_addr_o   out  ADDR_W  memory address (registered)
//  mem_wdata_o  out  DATA_W  memory write data (registered)
//  mem_rdata_i  in   DATA_W  memory read data, sampled on the mem_ack_i cycle
//  mem_ack_i    in   1       access-complete strobe
//  err_o        out  1       sticky: set on a watchdog abort; cleared only by reset
// BEHAVIOUR
//  Reset (rst_i=0, async): state IDLE; every output and every counter 0; any in-flight access is abandoned.
//  FSM states and transitions:
//   IDLE -> BUSY when any request is high.
//     Winner: DM if dm_req_i, else IF.
//     At the same edge: addr, we, wdata and owner are registered, mem_req_o goes 1, and the watchdog clears.
//     mem_we_o = dm_we_i when DM wins, else 0.
//   BUSY -> DONE on mem_ack_i.
//     At the same edge: mem_rdata_i is latched into the owner's rdata register; mem_req_o and mem_we_o go 0.
//   BUSY -> DONE on watchdog == TIMEOUT_CYC-1 without an ack.
//     rdata is forced to 0, err_o is set, mem_req_o goes 0.
//   DONE: owner's ready_o = 1 for exactly this cycle; all requests ignored; -> IDLE.
//  Latency and throughput:
//   Minimum latency is request-seen to ready = 3 cycles when the ack arrives in the first BUSY cycle.
//   Back-to-back accesses issue at most one every 3 cycles.
//  The non-owner's ready_o stays 0; its rdata_o holds its last value.
//  Requesters drop or change req at the edge ending their ready cycle.
//   A req still high in IDLE is a new access.
//  Simultaneous if_req_i and dm_req_i in IDLE: DM wins; IF stays stalled.
//  Requests arriving during BUSY/DONE wait; they are never lost.
//  mem_ack_i outside BUSY is ignored.
//  Watchdog counter width = $clog2(TIMEOUT_CYC); it saturates and never wraps.
// CONFIGURATION
//  Macro ARB_FAIR_EN, defined:
//   A streak counter counts DM grants made while if_req_i is high.
//   When the counter == MAX_DM_STREAK, the next IDLE arbitration with both requests high goes to IF.
//   The counter clears on any IF grant.
//  Macro not defined: strict DM priority; no streak counter; MAX_DM_STREAK is unused.
// STRUCTURE
//  Package mem_arb_pkg holds:
//   state_t enum {IDLE, BUSY, DONE}
//   owner_t enum {OWN_IF, OWN_DM}
//   default width localparams
//  Sub-module mem_arb_watchdog: clear/enable, saturating counter, expire pulse at TIMEOUT_CYC-1.
//  The rest (FSM, grant logic, capture registers) is flat in this module.
// TESTING
//  1. if_req_i=1, if_addr_i=0x10, ack in 1st BUSY cycle with rdata 0x8C020004
//     -> mem_addr_o=0x10 with mem_we_o=0; if_ready_o pulses 3 cycles after the request with if_rdata_o=0x8C020004.
//  2. if_req_i and dm_req_i rise together, dm_we_i=1, addr 0x20, wdata 0xDEADBEEF
//     -> DM served first (mem_we_o=1, mem_wdata_o=0xDEADBEEF);
//     -> then IF served; if_stall_o stays 1 until IF's DONE.
//  3. Ack delayed 5 cycles
//     -> mem_req_o, mem_addr_o stable throughout BUSY; dm_stall_o=1 throughout; dm_ready_o pulses once.
//  4. No ack, TIMEOUT_CYC=8
//     -> abort after 8 BUSY cycles; ready pulse with rdata=0; err_o=1 and held until reset.
//  5. rst_i driven low mid-BUSY
//     -> mem_req_o and all outputs 0 immediately (asynchronous); after release, IDLE re-arbitrates the held requests.
//  6. ARB_FAIR_EN, MAX_DM_STREAK=4, both requests held high
//     -> 4 DM grants, then 1 IF grant, streak clears, then DM again.
//     -> Without the macro: IF is never granted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and default sizes for mem_port_arbiter
package mem_arb_pkg;
    localparam int DEF_ADDR_W        = 32;
    localparam int DEF_DATA_W        = 32;
    localparam int DEF_TIMEOUT_CYC   = 64;
    localparam int DEF_MAX_DM_STREAK = 4;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/MEM requester, memory-side and status signals of mem_port_arbiter
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ready_o;
    logic              if_stall_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ready_o;
    logic              dm_stall_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;
    logic              err_o;
    modport slave (
        input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i, mem_ack_i,
        output if_rdata_o, if_ready_o, if_stall_o, dm_rdata_o, dm_ready_o, dm_stall_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );
    modport master (
        output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i, mem_ack_i,
        input  if_rdata_o, if_ready_o, if_stall_o, dm_rdata_o, dm_ready_o, dm_stall_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );
endinterface

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: saturating access timer; expire_o marks the TIMEOUT_CYC-th enabled cycle
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign expire_o = en_i & (cnt_q == LAST);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-port memory shared by IF and MEM, DM-first, watchdog per access.
// Define ARB_FAIR_EN to hand IF the grant after MAX_DM_STREAK DM grants made while IF waited.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC,
    parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK
) (
    input logic               clk_i,
    input logic               rst_i,
    mem_port_arbiter_if.slave bus
);
    state_t            state_q;
    owner_t            owner_q;
    logic              mem_req_q, mem_we_q, if_ready_q, dm_ready_q, err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q, rdata_d;
    logic              any_req, grant_dm, expire, fin;

    assign any_req = bus.if_req_i | bus.dm_req_i;
    assign fin     = bus.mem_ack_i | expire;
    assign rdata_d = bus.mem_ack_i ? bus.mem_rdata_i : '0;

`ifdef ARB_FAIR_EN
    localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
    logic [STREAK_W-1:0] streak_q;
    always_comb grant_dm = bus.dm_req_i & ~(bus.if_req_i & (streak_q == STREAK_W'(MAX_DM_STREAK)));
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                         streak_q <= '0;
        else if (state_q == IDLE && any_req) streak_q <= !grant_dm ? '0 : bus.if_req_i ? streak_q + 1'b1 : streak_q;
    end
`else
    always_comb grant_dm = bus.dm_req_i;
`endif

    mem_arb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (state_q != BUSY),
        .en_i    (state_q == BUSY),
        .expire_o(expire)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            case (state_q)
                IDLE: if (any_req) begin
                    state_q     <= BUSY;
                    owner_q     <= grant_dm ? OWN_DM : OWN_IF;
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= grant_dm & bus.dm_we_i;
                    mem_addr_q  <= grant_dm ? bus.dm_addr_i : bus.if_addr_i;
                    mem_wdata_q <= grant_dm ? bus.dm_wdata_i : '0;
                end
                BUSY: if (fin) begin
                    state_q   <= DONE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    err_q     <= err_q | ~bus.mem_ack_i;
                    if (owner_q == OWN_DM) begin
                        dm_rdata_q <= rdata_d;
                        dm_ready_q <= 1'b1;
                    end else begin
                        if_rdata_q <= rdata_d;
                        if_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.if_ready_o  = if_ready_q;
    assign bus.dm_ready_o  = dm_ready_q;
    assign bus.if_stall_o  = bus.if_req_i & ~if_ready_q;
    assign bus.dm_stall_o  = bus.dm_req_i & ~dm_ready_q;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus completion scoreboard and corner-case sequences
module tb_mem_port_arbiter;
    localparam int TO = 8;

    typedef struct {
        logic        dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rdata;
    } vec_t;
    typedef struct {
        logic        dm;
        logic [31:0] rdata;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO), .MAX_DM_STREAK(4)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    exp_t        sb[$];
    logic [31:0] grants[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          ack_dly = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic dm, input logic [31:0] rdata);
        exp_t e;
        e.dm    = dm;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'h8C020004 : (a ^ 32'h5A5A0000);
    endfunction

    task automatic serve(input logic dm, input logic [31:0] addr, input logic [31:0] exp);
        int t = 0;
        push_exp(dm, exp);
        if (dm) begin
            bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = addr;
        end else begin
            bus.if_req_i = 1'b1; bus.if_addr_i = addr;
        end
        do begin
            @(negedge clk_i);
            t++;
        end while (!(dm ? bus.dm_ready_o : bus.if_ready_o) && t < 100);
        check("serve_done", t < 100, 1);
        bus.if_req_i = 1'b0;
        bus.dm_req_i = 1'b0;
        @(negedge clk_i);
    endtask

    // memory model: ack after ack_dly BUSY cycles (never when negative), junk rdata otherwise
    initial begin
        int bc;
        bc = 0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'hBADBAD00;
        forever begin
            @(negedge clk_i);
            if (bus.mem_req_o) begin
                bus.mem_ack_i   = (bc == ack_dly);
                bus.mem_rdata_i = (bc == ack_dly) ? rd_fn(bus.mem_addr_o) : 32'hBADBAD00;
                bc++;
            end else begin
                bus.mem_ack_i   = 1'b0;
                bus.mem_rdata_i = 32'hBADBAD00;
                bc = 0;
            end
        end
    end

    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (bus.mem_req_o && !prev) grants.push_back(bus.mem_addr_o);
            prev = bus.mem_req_o;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (bus.if_ready_o || bus.dm_ready_o) begin
                if (sb.size() == 0) check("sb_unexpected", {bus.if_ready_o, bus.dm_ready_o}, 0);
                else begin
                    e = sb.pop_front();
                    check("sb_owner", {bus.if_ready_o, bus.dm_ready_o}, e.dm ? 2'b01 : 2'b10);
                    check("sb_rdata", e.dm ? bus.dm_rdata_o : bus.if_rdata_o, e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       vec[5];
        vec_t       v;
        int         lat, done;
        logic       st_ok, stb_ok, rdy;
        logic [5:0] fair_pat;
        vec[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        0, 32'h8C020004};
        vec[1] = '{1'b1, 1'b0, 32'h40,  32'h0,        0, 32'h5A5A0040};
        vec[2] = '{1'b1, 1'b1, 32'h44,  32'h12345678, 1, 32'h5A5A0044};
        vec[3] = '{1'b0, 1'b0, 32'h104, 32'h0,        2, 32'h5A5A0104};
        vec[4] = '{1'b1, 1'b0, 32'h80,  32'h0,        5, 32'h5A5A0080};
        bus.if_req_i = 1'b0; bus.if_addr_i = '0;
        bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0; bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
        repeat (2) @(negedge clk_i);
        check("rst_ctrl", {bus.mem_req_o, bus.mem_we_o, bus.if_ready_o, bus.dm_ready_o, bus.err_o}, 0);
        check("rst_addr", bus.mem_addr_o, 0);
        check("rst_rdata", {bus.if_rdata_o, bus.dm_rdata_o}, 0);
        rst_i = 1'b1;
        @(negedge clk_i);

        for (int k = 0; k < 5; k++) begin
            v = vec[k];
            ack_dly = v.dly;
            push_exp(v.dm, v.rdata);
            if (v.dm) begin
                bus.dm_req_i = 1'b1; bus.dm_we_i = v.we; bus.dm_addr_i = v.addr; bus.dm_wdata_i = v.wdata;
            end else begin
                bus.if_req_i = 1'b1; bus.if_addr_i = v.addr;
            end
            lat = 1; st_ok = 1'b1; stb_ok = 1'b1; rdy = 1'b0;
            @(negedge clk_i);
            lat++;
            check("issue_addr", bus.mem_addr_o, v.addr);
            check("issue_req_we", {bus.mem_req_o, bus.mem_we_o}, {1'b1, v.we});
            if (v.we) check("issue_wdata", bus.mem_wdata_o, v.wdata);
            while (lat < 100) begin
                rdy = v.dm ? bus.dm_ready_o : bus.if_ready_o;
                if (rdy) break;
                st_ok  &= v.dm ? bus.dm_stall_o : bus.if_stall_o;
                stb_ok &= bus.mem_req_o && (bus.mem_addr_o == v.addr);
                @(negedge clk_i);
                lat++;
            end
            check("ready_seen", rdy, 1);
            check("latency", lat, v.dly + 3);
            check("stall_held", st_ok, 1);
            check("busy_stable", stb_ok, 1);
            check("stall_at_ready", v.dm ? bus.dm_stall_o : bus.if_stall_o, 0);
            check("other_ready", v.dm ? bus.if_ready_o : bus.dm_ready_o, 0);
            bus.if_req_i = 1'b0;
            bus.dm_req_i = 1'b0;
            @(negedge clk_i);
            check("ready_pulse", {bus.if_ready_o, bus.dm_ready_o}, 0);
        end

        ack_dly = 0;
        grants.delete();
        push_exp(1'b1, 32'h5A5A0020);
        push_exp(1'b0, 32'h5A5A0030);
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_addr_i = 32'h20; bus.dm_wdata_i = 32'hDEADBEEF;
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h30;
        lat = 1; st_ok = 1'b1;
        @(negedge clk_i);
        lat++;
        check("dual_dm_first", {bus.mem_addr_o, bus.mem_we_o}, {32'h20, 1'b1});
        check("dual_wdata", bus.mem_wdata_o, 32'hDEADBEEF);
        while (!bus.if_ready_o && lat < 100) begin
            st_ok &= bus.if_stall_o;
            if (bus.dm_ready_o) begin
                check("dual_dm_lat", lat, 3);
                bus.dm_req_i = 1'b0;
            end
            @(negedge clk_i);
            lat++;
        end
        check("dual_if_lat", lat, 6);
        check("dual_if_stall", st_ok, 1);
        check("dual_grant_cnt", grants.size(), 2);
        check("dual_grant_if", grants.size() > 1 ? grants[1] : 32'h0, 32'h30);
        bus.if_req_i = 1'b0;
        @(negedge clk_i);

        ack_dly = -1;
        push_exp(1'b1, 32'h0);
        check("err_before", bus.err_o, 0);
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h300;
        lat = 0; done = 0;
        @(negedge clk_i);
        while (!bus.dm_ready_o && done < 100) begin
            if (bus.mem_req_o) lat++;
            done++;
            @(negedge clk_i);
        end
        check("wd_busy_cycles", lat, TO);
        check("wd_err_set", bus.err_o, 1);
        check("wd_rdata", bus.dm_rdata_o, 0);
        bus.dm_req_i = 1'b0;
        @(negedge clk_i);
        ack_dly = 0;
        serve(1'b0, 32'h104, 32'h5A5A0104);
        check("err_sticky", bus.err_o, 1);

        ack_dly = -1;
        push_exp(1'b1, 32'h5A5A0400);
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h400;
        repeat (3) @(negedge clk_i);
        check("pre_rst_busy", bus.mem_req_o, 1);
        rst_i = 1'b0;
        #1;
        check("arst_ctrl", {bus.mem_req_o, bus.mem_we_o, bus.if_ready_o, bus.dm_ready_o, bus.err_o}, 0);
        check("arst_addr", bus.mem_addr_o, 0);
        check("arst_rdata", {bus.if_rdata_o, bus.dm_rdata_o}, 0);
        ack_dly = 0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rearb", {bus.mem_req_o, bus.mem_addr_o}, {1'b1, 32'h400});
        done = 0;
        while (!bus.dm_ready_o && done < 100) begin
            @(negedge clk_i);
            done++;
        end
        check("rearb_done", bus.dm_ready_o, 1);
        bus.dm_req_i = 1'b0;
        @(negedge clk_i);

`ifdef ARB_FAIR_EN
        fair_pat = 6'b010000;
`else
        fair_pat = 6'b000000;
`endif
        grants.delete();
        for (int i = 0; i < 6; i++) push_exp(!fair_pat[i], fair_pat[i] ? 32'h5A5A0100 : 32'h5A5A0200);
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h200;
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
        done = 0; lat = 0;
        while (done < 6 && lat < 300) begin
            @(negedge clk_i);
            lat++;
            if (bus.if_ready_o || bus.dm_ready_o) done++;
        end
        bus.dm_req_i = 1'b0;
        bus.if_req_i = 1'b0;
        check("fair_done", done, 6);
        check("fair_grant_cnt", grants.size(), 6);
        for (int i = 0; i < 6; i++)
            check("fair_grant", grants.size() > i ? grants[i] : 32'h0, fair_pat[i] ? 32'h100 : 32'h200);
        repeat (3) @(negedge clk_i);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
